// File: rtl/video_pattern_source.sv
// Framed video test-pattern source: emits frame/line/pixel envelopes and
// deterministic Bayer-domain patterns, PPC pixels per beat, with backpressure.

// Per-pixel pattern generator; one instance per lane of the beat.
module video_pattern_source_lane #(
    parameter int PIX_W = 10,
    parameter int CW    = 11,
    parameter int K     = 0
) (
    input  logic [1:0]       pat_i,
    input  logic [PIX_W-1:0] line_i,
    input  logic [CW-1:0]    col_i,
    input  logic [PIX_W-1:0] idx_i,
    output logic [PIX_W-1:0] pix_o
);
    // Column of this lane is col_i+K, so its parity flips with odd K.
    localparam logic K_ODD = (K % 2) == 1;

    // Pattern value for column col_i+K on line line_i.
    always_comb begin
        pix_o = '0;
        case (pat_i)
            2'd0: begin
                if (!line_i[0]) pix_o = (col_i[0] ^ K_ODD) ? PIX_W'(32'h100) : PIX_W'(32'h200);
                else            pix_o = (col_i[0] ^ K_ODD) ? PIX_W'(32'h080) : PIX_W'(32'h100);
            end
            2'd1:    pix_o = PIX_W'(32'(col_i) + 32'(K));
            2'd2:    pix_o = line_i;
            default: pix_o = idx_i + PIX_W'(K);
        endcase
    end
endmodule

module video_pattern_source #(
    parameter int PIX_W     = 10,
    parameter int PPC       = 4,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 512,
    parameter int H_BLANK   = 16,
    parameter int V_FRONT   = 8,
    parameter int V_BACK    = 8,
    parameter int FRAME_GAP = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic [1:0]           pattern_sel_i,
    input  logic                 ready_i,
    output logic                 frame_valid_o,
    output logic                 line_valid_o,
    output logic                 pix_valid_o,
    output logic [PIX_W*PPC-1:0] pix_data_o,
    output logic [11:0]          line_cnt_o,
    output logic                 frame_done_o
);
    localparam int CW = $clog2(H_ACTIVE) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FRONT = 3'd1;
    localparam logic [2:0] S_ACT   = 3'd2;
    localparam logic [2:0] S_BLANK = 3'd3;
    localparam logic [2:0] S_BACK  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]       state;
    logic [15:0]      tmr;   // cycle counter for the fixed-length phases
    logic [CW-1:0]    col;   // first column of the current beat
    logic [11:0]      line;
    logic [PIX_W-1:0] idx;   // running pixel index within the frame, wraps at 2^PIX_W
    logic [1:0]       pat;   // pattern latched at frame start
    logic             done;

    logic last_beat;
    assign last_beat = (col == CW'(H_ACTIVE - PPC));

    // Frame sequencer; stalls in S_ACT hold every counter while ready_i is low.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= S_IDLE;
            tmr   <= '0;
            col   <= '0;
            line  <= '0;
            idx   <= '0;
            pat   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable_i) begin
                        state <= S_FRONT;
                        pat   <= pattern_sel_i;
                        idx   <= '0;
                        line  <= '0;
                        col   <= '0;
                        tmr   <= '0;
                    end
                end
                S_FRONT: begin
                    if (tmr == 16'(V_FRONT - 1)) begin
                        state <= S_ACT;
                        tmr   <= '0;
                    end else tmr <= tmr + 16'd1;
                end
                S_ACT: begin
                    if (ready_i) begin
                        idx <= idx + PIX_W'(PPC);
                        if (last_beat) begin
                            col <= '0;
                            tmr <= '0;
                            if (line == 12'(V_ACTIVE - 1)) state <= S_BACK;
                            else begin
                                state <= S_BLANK;
                                line  <= line + 12'd1;
                            end
                        end else col <= col + CW'(PPC);
                    end
                end
                S_BLANK: begin
                    if (tmr == 16'(H_BLANK - 1)) begin
                        state <= S_ACT;
                        tmr   <= '0;
                    end else tmr <= tmr + 16'd1;
                end
                S_BACK: begin
                    if (tmr == 16'(V_BACK - 1)) begin
                        state <= S_GAP;
                        done  <= 1'b1;
                        tmr   <= '0;
                    end else tmr <= tmr + 16'd1;
                end
                S_GAP: begin
                    if (tmr == 16'(FRAME_GAP - 1)) begin
                        tmr  <= '0;
                        line <= '0;
                        idx  <= '0;
                        if (enable_i) begin
                            state <= S_FRONT;
                            pat   <= pattern_sel_i;
                        end else state <= S_IDLE;
                    end else tmr <= tmr + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [PPC-1:0][PIX_W-1:0] pix;
    logic [PIX_W-1:0]          line_m;
    assign line_m = PIX_W'(line);

    for (genvar k = 0; k < PPC; k++) begin : g_lane
        video_pattern_source_lane #(.PIX_W(PIX_W), .CW(CW), .K(k)) u_lane (
            .pat_i  (pat),
            .line_i (line_m),
            .col_i  (col),
            .idx_i  (idx),
            .pix_o  (pix[k])
        );
    end

    assign frame_valid_o = (state == S_FRONT) || (state == S_ACT) ||
                           (state == S_BLANK) || (state == S_BACK);
    assign line_valid_o  = (state == S_ACT);
    assign pix_valid_o   = (state == S_ACT);
    assign pix_data_o    = (state == S_ACT) ? pix : '0;
    assign line_cnt_o    = line;
    assign frame_done_o  = done;
endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboarded bench for video_pattern_source on a reduced frame geometry.
module tb_video_pattern_source;
    localparam int PIX_W = 10, PPC = 4, H_ACTIVE = 64, V_ACTIVE = 20;
    localparam int H_BLANK = 3, V_FRONT = 4, V_BACK = 5, FRAME_GAP = 6;
    localparam int BEATS = H_ACTIVE / PPC;
    localparam int FV_CYCLES = V_FRONT + V_ACTIVE * BEATS + (V_ACTIVE - 1) * H_BLANK + V_BACK;

    typedef struct packed {
        logic [PIX_W*PPC-1:0] data;
        logic [11:0]          line;
    } beat_t;

    logic clk = 1'b0, reset_n_i, enable_i, ready_i;
    logic [1:0] pattern_sel_i;
    logic frame_valid_o, line_valid_o, pix_valid_o, frame_done_o;
    logic [PIX_W*PPC-1:0] pix_data_o;
    logic [11:0] line_cnt_o;

    video_pattern_source #(
        .PIX_W(PIX_W), .PPC(PPC), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .H_BLANK(H_BLANK), .V_FRONT(V_FRONT), .V_BACK(V_BACK), .FRAME_GAP(FRAME_GAP)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .enable_i(enable_i), .pattern_sel_i(pattern_sel_i),
        .ready_i(ready_i), .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o),
        .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o), .line_cnt_o(line_cnt_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0, n_bad = 0;
    int    fv_hi = 0, done_cnt = 0;
    bit    rand_ready = 1'b0;
    beat_t sbq[$];

    // monitor state
    bit pfv = 1'b0, plv = 1'b0, seen = 1'b0;
    int run = 0, beats = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference pixel value from the pattern definitions.
    function automatic int model(input int p, input int r, input int c);
        case (p)
            0:       return (r % 2 == 0) ? ((c % 2 == 0) ? 'h200 : 'h100)
                                         : ((c % 2 == 0) ? 'h100 : 'h080);
            1:       return c % (1 << PIX_W);
            2:       return r % (1 << PIX_W);
            default: return (r * H_ACTIVE + c) % (1 << PIX_W);
        endcase
    endfunction

    task automatic push_frame(input int p);
        beat_t e;
        for (int r = 0; r < V_ACTIVE; r++)
            for (int b = 0; b < BEATS; b++) begin
                e.line = 12'(r);
                for (int k = 0; k < PPC; k++)
                    e.data[k*PIX_W +: PIX_W] = PIX_W'(model(p, r, b * PPC + k));
                sbq.push_back(e);
            end
    endtask

    function automatic bit hit(input int what);
        case (what)
            0:       return frame_valid_o;
            1:       return frame_done_o;
            default: return pix_valid_o && (line_cnt_o == 12'd2);
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!hit(what) && n < budget);
        if (!hit(what)) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_%0d: timed out after %0d cycles", what, n);
        end
    endtask

    task automatic check_idle(input string nm);
        check(nm, {frame_valid_o, line_valid_o, pix_valid_o, pix_data_o, line_cnt_o, frame_done_o}, '0);
    endtask

    // One frame from IDLE; enable dropped and pattern scrambled once the frame starts.
    task automatic run_frame(input int p);
        int fv0, dn0;
        @(negedge clk);
        pattern_sel_i = 2'(p);
        enable_i = 1'b1;
        push_frame(p);
        fv0 = fv_hi;
        dn0 = done_cnt;
        wait_for(0, 200);
        enable_i = 1'b0;
        pattern_sel_i = 2'($urandom);
        wait_for(1, 20000);
        repeat (FRAME_GAP + 2) @(negedge clk);
        if (!rand_ready) check("fv_cycles", 64'(fv_hi - fv0), 64'(FV_CYCLES));
        check("done_count", 64'(done_cnt - dn0), 64'd1);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        check_idle("idle_after_frame");
    endtask

    // Downstream ready: always 1 or a 50% coin per cycle.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1 ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on accepted beats and checks envelope timing.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset_n_i) begin
                pfv = 0; plv = 0; seen = 0; run = 0; beats = 0;
            end else begin
                check("done_pulse", 64'(frame_done_o), 64'(pfv && !frame_valid_o));
                check("lv_eq_pv", 64'(line_valid_o), 64'(pix_valid_o));
                if (frame_done_o) done_cnt++;
                if (frame_valid_o) fv_hi++;
                if (line_valid_o && !plv) check(seen ? "blank_run" : "front_run", 64'(run), 64'(seen ? H_BLANK : V_FRONT));
                if (!frame_valid_o && pfv && seen) check("back_run", 64'(run), 64'(V_BACK));
                if (plv && !line_valid_o) begin
                    check("line_beats", 64'(beats), 64'(BEATS));
                    beats = 0;
                end
                if (pix_valid_o) begin
                    if (sbq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_beat: got %0h expected none", pix_data_o);
                    end else begin
                        e = sbq[0];
                        check("beat_data", 64'(pix_data_o), 64'(e.data));
                        check("beat_line", 64'(line_cnt_o), 64'(e.line));
                        if (ready_i) begin
                            void'(sbq.pop_front());
                            beats++;
                        end
                    end
                end
                if (frame_valid_o && !line_valid_o) run++; else run = 0;
                if (line_valid_o) seen = 1;
                if (!frame_valid_o) seen = 0;
                pfv = frame_valid_o;
                plv = line_valid_o;
            end
        end
    end

    // Main sequence.
    initial begin
        int gap;
        reset_n_i = 1'b0;
        enable_i = 1'b0;
        pattern_sel_i = 2'd0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("idle_no_enable");

        // full-rate frames, every pattern
        for (int p = 0; p < 4; p++) run_frame(p);

        // backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 4; p++) run_frame(3 - p);

        // back-to-back frames with pattern re-latched in the gap
        rand_ready = 1'b0;
        @(negedge clk);
        pattern_sel_i = 2'd3;
        enable_i = 1'b1;
        push_frame(3);
        wait_for(0, 200);
        wait_for(1, 20000);
        pattern_sel_i = 2'd2;
        push_frame(2);
        gap = 1;
        while (gap < 200) begin
            @(negedge clk);
            if (frame_valid_o) break;
            gap++;
        end
        check("frame_gap", 64'(gap), 64'(FRAME_GAP));
        enable_i = 1'b0;
        pattern_sel_i = 2'd1;
        wait_for(1, 20000);
        repeat (FRAME_GAP + 2) @(negedge clk);
        check("sb_empty_b2b", 64'(sbq.size()), 64'd0);
        check_idle("idle_after_b2b");

        // asynchronous reset mid-line, then a clean frame from line 0 column 0
        rand_ready = 1'b1;
        @(negedge clk);
        pattern_sel_i = 2'd1;
        enable_i = 1'b1;
        push_frame(1);
        wait_for(2, 2000);
        #1 reset_n_i = 1'b0;
        #1 check_idle("async_reset");
        sbq.delete();
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        run_frame(1);
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
